// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, reads words over imem req/ack into a prefetch FIFO, one instr per cycle to decode.
// Latency: a word acked in cycle N is on data_out in cycle N+1; zero-wait memory sustains one instruction per cycle.
// Backpressure: stall holds the FIFO head; fetching pauses when the FIFO is full. Optional macro FETCH_MISALIGN_CHECK_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] data_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        misalign
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   req_addr, req_addr_nxt;
  logic [31:0]   pc_hold;
  logic          misalign_q, misalign_nxt;
  logic [31:0]   fifo_pc  [FIFO_DEPTH];
  logic [31:0]   fifo_dat [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] post_cnt;
  logic          push, pop, flush;
  logic [31:0]   redir_tgt;
  logic          redir_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_tgt = redirect_pc;
  assign redir_bad = (redirect_pc[1:0] != 2'b00);
`else
  // Low address bits are meaningless for word fetch, so they are simply dropped.
  assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign redir_bad = 1'b0;
`endif

  assign valid_out = (count != '0);
  assign data_out  = valid_out ? fifo_dat[rd_ptr] : NOP;
  assign pc_out    = valid_out ? fifo_pc[rd_ptr]  : pc_hold;
  assign imem_req  = (state != IDLE);
  assign imem_addr = req_addr;
  assign misalign  = misalign_q;
  // A redirect flushes the FIFO, so the head is never consumed in that cycle.
  assign pop       = valid_out && !stall && !redirect;
  assign post_cnt  = {1'b0, count} + (AW+2)'(1) - (AW+2)'(pop);

  // Next-state and fetch control; redirect takes priority over everything else.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_addr_nxt = req_addr;
    misalign_nxt = misalign_q;
    push         = 1'b0;
    flush        = 1'b0;
    if (redirect) begin
      flush        = 1'b1;
      fetch_pc_nxt = redir_tgt;
      misalign_nxt = redir_bad;
      case (state)
        IDLE: begin
          if (!redir_bad) begin
            state_nxt    = REQ;
            req_addr_nxt = redir_tgt;
          end
        end
        default: begin
          // An outstanding request either completes now (data dropped) or must be drained in DROP.
          if (imem_ack) begin
            state_nxt    = redir_bad ? IDLE : REQ;
            req_addr_nxt = redir_tgt;
          end else begin
            state_nxt = DROP;
          end
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (!misalign_q && count < DEPTH_C) begin
            state_nxt    = REQ;
            req_addr_nxt = fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + 32'd4;
            if (post_cnt < {1'b0, DEPTH_C}) begin
              req_addr_nxt = fetch_pc + 32'd4;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_nxt    = misalign_q ? IDLE : REQ;
            req_addr_nxt = fetch_pc;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control registers: FSM state, fetch PC, request address, sticky misalign flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      req_addr   <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      req_addr   <= req_addr_nxt;
      misalign_q <= misalign_nxt;
    end
  end

  // FIFO pointers, occupancy and the pc shown while empty (last head presented).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pc_hold <= 32'h0;
    end else begin
      if (valid_out) pc_hold <= fifo_pc[rd_ptr];
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + (AW+1)'(1);
        else if (!push && pop) count <= count - (AW+1)'(1);
      end
    end
  end

  // FIFO storage; entries are tagged with the PC they were fetched from.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_pc[wr_ptr]  <= fetch_pc;
      fifo_dat[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory responder with programmable ack latency,
// scoreboard of expected (pc, data) pairs, table of redirect vectors, hand-written corner sequences.
module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] data_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        misalign;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int pass_cnt = 0;
  int total    = 0;
  int lat      = 0;
  int wait_cnt;
  logic [31:0] sb[$];

  typedef struct {
    logic [31:0] redir_pc;
    int          lat;
    logic [31:0] exp_first;
    int          n;
  } vec_t;
  vec_t vecs[4];

  instruction_fetch dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .data_out(data_out), .pc_out(pc_out), .valid_out(valid_out), .misalign(misalign)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: acks after `lat` wait cycles of a held request (lat=0 -> same-cycle ack).
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = mem_word(imem_addr);
  always @(posedge clock or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: compare head while valid; consume on a pop.
  always @(negedge clock) begin
    if (!reset && !redirect && valid_out && sb.size() > 0) begin
      chk("sb_pc", pc_out, sb[0]);
      chk("sb_data", data_out, mem_word(sb[0]));
      if (!stall) void'(sb.pop_front());
    end
  end

  task automatic do_redirect(input logic [31:0] pc, input logic [31:0] first, input int n);
    redirect    = 1'b1;
    redirect_pc = pc;
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back(first + 32'(4 * i));
    @(posedge clock); #1;
    redirect = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 400 && sb.size() > 0; c++) @(posedge clock);
    chk(name, 32'(sb.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic wait_addr(input string name, input logic [31:0] a);
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (imem_req && imem_addr == a) break;
    end
    chk(name, imem_addr, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 4};
    vecs[1] = '{32'hFFFF_FFFC, 2, 32'hFFFF_FFFC, 3};
    vecs[2] = '{32'h0000_1000, 1, 32'h0000_1000, 3};
`ifdef FETCH_MISALIGN_CHECK_EN
    vecs[3] = '{32'h0000_0104, 0, 32'h0000_0104, 3};
`else
    vecs[3] = '{32'h0000_0102, 0, 32'h0000_0100, 3};
`endif

    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", data_out, NOP);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'd0);

    // Zero-wait stream from reset.
    for (int i = 0; i < 8; i++) sb.push_back(32'(4 * i));
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("c0_req", 32'(imem_req), 32'd0);
    @(negedge clock);
    chk("c1_req", 32'(imem_req), 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    chk("c1_valid", 32'(valid_out), 32'd0);
    @(negedge clock);
    chk("c2_valid", 32'(valid_out), 32'd1);
    chk("c2_addr", imem_addr, 32'h4);
    drain("drain_reset_stream");

    // Stall fills FIFO, request drops, head frozen.
    stall = 1'b1;
    do_redirect(32'h40, 32'h40, 8);
    repeat (5) @(posedge clock);
    #1;
    @(negedge clock);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(valid_out), 32'd1);
    chk("full_pc", pc_out, 32'h40);
    @(posedge clock); #1;
    stall = 1'b0;
    drain("drain_stall");

    // Redirect while a 3-cycle-latency request is outstanding.
    lat = 3;
    do_redirect(32'h80, 32'h80, 0);
    wait_addr("lat_addr80", 32'h80);
    @(posedge clock); #1;
    do_redirect(32'h100, 32'h100, 4);
    @(negedge clock);
    chk("drop_valid", 32'(valid_out), 32'd0);
    chk("drop_data", data_out, NOP);
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr_hold", imem_addr, 32'h80);
    wait_addr("lat_addr100", 32'h100);
    drain("drain_lat");

    // Redirect with same-cycle ack while FIFO holds 3.
    lat = 0;
    stall = 1'b1;
    do_redirect(32'h200, 32'h200, 1);
    repeat (3) @(posedge clock);
    #1;
    stall = 1'b0;
    do_redirect(32'h300, 32'h300, 4);
    @(negedge clock);
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_data", data_out, NOP);
    chk("flush_pc_hold", pc_out, 32'h200);
    chk("flush_addr", imem_addr, 32'h300);
    @(posedge clock); #1;
    drain("drain_flush");

    // Table of redirect vectors.
    for (int v = 0; v < 4; v++) begin
      lat = vecs[v].lat;
      do_redirect(vecs[v].redir_pc, vecs[v].exp_first, vecs[v].n);
      @(negedge clock);
      chk("vec_misalign", 32'(misalign), 32'd0);
      @(posedge clock); #1;
      drain("drain_vec");
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    lat = 0;
    do_redirect(32'h102, 32'h0, 0);
    @(negedge clock);
    chk("mis_set", 32'(misalign), 32'd1);
    chk("mis_valid", 32'(valid_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("mis_noreq", 32'(imem_req), 32'd0);
    end
    @(posedge clock); #1;
    do_redirect(32'h200, 32'h200, 3);
    @(negedge clock);
    chk("mis_clear", 32'(misalign), 32'd0);
    chk("mis_addr", imem_addr, 32'h200);
    @(posedge clock); #1;
    drain("drain_mis");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
